simplebus_leader_engine: RTL



---
 rtl/simplebus_leader_engine_if.sv | 27 ++
 rtl/simplebus_leader_engine.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/simplebus_leader_engine_if.sv
// Processor-side command/response port of the simplebus leader engine.
//   cmd_*  : command offer (valid/ready), read flag, 24-bit address, write data
//   rsp_*  : one-cycle completion pulse with read flag, read data and error
//   busy   : engine has work in flight or queued
// master = command producer, slave = engine.
interface simplebus_leader_engine_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_read;
  logic [23:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid;
  logic        rsp_read;
  logic [7:0]  rsp_data;
  logic        rsp_error;
  logic        busy;

  modport master (
    output cmd_valid, cmd_read, cmd_addr, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_read, rsp_data, rsp_error, busy
  );

  modport slave (
    input  cmd_valid, cmd_read, cmd_addr, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_read, rsp_data, rsp_error, busy
  );
endinterface

// File: rtl/simplebus_leader_engine.sv
// Queued simplebus leader: buffers processor commands in a FIFO and replays
// each as start/upper, mid, low address phases followed by a write-data or
// read-wait phase, then issues one response and a turnaround gap.
// Ports:
//   clock, reset     : single clock, synchronous active-high reset
//   cmd_if (slave)   : command/response handshake and busy flag
//   bus_start        : high during the upper-address phase
//   bus_read         : high during the low-address phase of a read
//   bus_address      : address byte during address phases, else released
//   bus_data         : driven with write data in the data phase, else released
//   bus_dataValid    : driven high in the data phase, else released
// All outputs are registered; the bus drive enables are registered too.
module simplebus_leader_engine #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                            clock,
  input  logic                            reset,
  simplebus_leader_engine_if.slave        cmd_if,
  output logic                            bus_start,
  output logic                            bus_read,
  output wire  [7:0]                      bus_address,
  inout  wire  [7:0]                      bus_data,
  inout  wire                             bus_dataValid
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, ADDR_UP, ADDR_MID, ADDR_LO, WR_DATA, RD_WAIT, RESP, GAP
  } state_e;

  typedef struct packed {
    logic        rd;
    logic [23:0] addr;
    logic [7:0]  wdata;
  } cmd_t;

  cmd_t          fifo_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          push_c, pop_c;

  state_e        state_q, state_d;
  cmd_t          work_q, work_d;
  logic [CW-1:0] tmo_q, tmo_d;

  logic          ready_q, ready_d;
  logic          busy_q, busy_d;
  logic          start_q, start_d;
  logic          read_q, read_d;
  logic          addr_oe_q, addr_oe_d;
  logic [7:0]    addr_byte_q, addr_byte_d;
  logic          data_oe_q, data_oe_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_read_q, rsp_read_d;
  logic          rsp_error_q, rsp_error_d;
  logic [7:0]    rsp_data_q, rsp_data_d;

  // Only a clean 1 counts as valid; x/z from an unclaimed bus is ignored.
  logic dv_c;
  assign dv_c = (bus_dataValid === 1'b1);

  // Next state plus the output values that the next state will present.
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    tmo_d       = tmo_q;
    pop_c       = 1'b0;
    rsp_data_d  = '0;
    rsp_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = ADDR_UP;
          pop_c   = 1'b1;
          work_d  = fifo_q[rd_ptr_q];
        end
      end
      ADDR_UP:  state_d = ADDR_MID;
      ADDR_MID: state_d = ADDR_LO;
      ADDR_LO: begin
        state_d = work_q.rd ? RD_WAIT : WR_DATA;
        tmo_d   = '0;
      end
      WR_DATA:  state_d = RESP;
      RD_WAIT: begin
        if (dv_c) begin
          state_d    = RESP;
          rsp_data_d = bus_data;
        end else if (tmo_q == CW'(TIMEOUT - 1)) begin
          state_d     = RESP;
          rsp_error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RESP:     state_d = GAP;
      GAP:      state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    push_c  = cmd_if.cmd_valid && ready_q;
    count_d = count_q + (PW+1)'(push_c) - (PW+1)'(pop_c);

    // Outputs are decoded from the next state so they line up with it.
    start_d   = (state_d == ADDR_UP);
    addr_oe_d = (state_d inside {ADDR_UP, ADDR_MID, ADDR_LO});
    case (state_d)
      ADDR_UP:  addr_byte_d = work_d.addr[23:16];
      ADDR_MID: addr_byte_d = work_d.addr[15:8];
      ADDR_LO:  addr_byte_d = work_d.addr[7:0];
      default:  addr_byte_d = '0;
    endcase
    read_d      = (state_d == ADDR_LO) && work_d.rd;
    data_oe_d   = (state_d == WR_DATA);
    rsp_valid_d = (state_d == RESP);
    rsp_read_d  = (state_d == RESP) && work_d.rd;
    ready_d     = (count_d < (PW+1)'(DEPTH));
    busy_d      = (state_d != IDLE) || (count_d != '0);
  end

  // Control and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      work_q      <= '0;
      tmo_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      start_q     <= 1'b0;
      read_q      <= 1'b0;
      addr_oe_q   <= 1'b0;
      addr_byte_q <= '0;
      data_oe_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_read_q  <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      tmo_q       <= tmo_d;
      count_q     <= count_d;
      if (push_c) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_c)  rd_ptr_q <= rd_ptr_q + 1'b1;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      read_q      <= read_d;
      addr_oe_q   <= addr_oe_d;
      addr_byte_q <= addr_byte_d;
      data_oe_q   <= data_oe_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_read_q  <= rsp_read_d;
      rsp_error_q <= rsp_error_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // FIFO storage; stale entries are harmless because pointers are reset.
  always_ff @(posedge clock) begin
    if (push_c) fifo_q[wr_ptr_q] <= '{rd: cmd_if.cmd_read, addr: cmd_if.cmd_addr,
                                      wdata: cmd_if.cmd_wdata};
  end

  assign cmd_if.cmd_ready = ready_q;
  assign cmd_if.busy      = busy_q;
  assign cmd_if.rsp_valid = rsp_valid_q;
  assign cmd_if.rsp_read  = rsp_read_q;
  assign cmd_if.rsp_error = rsp_error_q;
  assign cmd_if.rsp_data  = rsp_data_q;

  assign bus_start     = start_q;
  assign bus_read      = read_q;
  assign bus_address   = addr_oe_q ? addr_byte_q : 8'hzz;
  assign bus_data      = data_oe_q ? work_q.wdata : 8'hzz;
  assign bus_dataValid = data_oe_q ? 1'b1 : 1'bz;

endmodule
